// File: rtl/ifetch_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_buffer
// Instruction-fetch front end for the single-cycle datapath. It reads the
// byte-wide instruction memory one byte per clock and assembles big-endian
// 32-bit words (the byte at the lowest address lands in bits 31:24). Each
// finished word is queued with its PC in a small FIFO and offered downstream
// over a valid/ready handshake. A redirect flushes everything in flight and
// restarts fetch at the new word-aligned PC.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          synchronous active-high reset (beats redirect)
//   imem_addr      byte address to instruction memory (fpc + byte index)
//   imem_rdata     byte returned combinationally for imem_addr
//   redirect_valid load redirect_pc as the new fetch PC this cycle
//   redirect_pc    new fetch PC, bits 1:0 ignored
//   inst_valid     FIFO head holds an instruction
//   inst_data      head instruction, zero when empty
//   inst_pc        PC of head instruction, zero when empty
//   inst_ready     consumer takes the head this cycle
//   fifo_count     number of queued instructions
// ---------------------------------------------------------------------------
module ifetch_buffer #(
   parameter int          ADDR_W   = 5,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [7:0]                 imem_rdata,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       inst_valid,
   output logic [31:0]                inst_data,
   output logic [31:0]                inst_pc,
   input  logic                       inst_ready,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      fpc;
   logic [1:0]       cnt;
   logic [23:0]      asm_reg;
   logic [31:0]      fifo_pc   [DEPTH];
   logic [31:0]      fifo_data [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic full;
   logic pop;
   logic advance;
   logic push;

   // Handshake and flow control. Fetch only stalls when the FIFO is full and
   // nothing leaves this cycle; a push is suppressed by a redirect or reset.
   always_comb begin
      full    = (count == CNT_W'(DEPTH));
      pop     = inst_valid && inst_ready;
      advance = !(full && !pop);
      push    = advance && (cnt == 2'd3) && !redirect_valid && !reset;
   end

   // The byte address walks through the current word; it wraps around the
   // small memory naturally through the truncated add.
   always_comb begin
      imem_addr = fpc[ADDR_W-1:0] + ADDR_W'(cnt);
   end

   // Head of the queue, forced to zero when empty so the consumer never sees
   // stale or uninitialised storage.
   always_comb begin
      inst_valid = (count != '0);
      inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'h0;
      inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
      fifo_count = count;
   end

   // Fetch sequencing, FIFO pointers and occupancy. Reset wins over redirect,
   // and redirect wins over any assembly or push. A pop in a redirect cycle
   // needs no bookkeeping because the whole queue is discarded anyway.
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc     <= RESET_PC;
         cnt     <= 2'd0;
         asm_reg <= 24'h0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else if (redirect_valid) begin
         fpc     <= redirect_pc & 32'hFFFF_FFFC;
         cnt     <= 2'd0;
         asm_reg <= 24'h0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else begin
         if (advance) begin
            if (cnt == 2'd3) begin
               fpc <= fpc + 32'd4;
               cnt <= 2'd0;
            end else begin
               asm_reg <= {asm_reg[15:0], imem_rdata};
               cnt     <= cnt + 2'd1;
            end
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage needs no reset; entries are only visible once written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]   <= fpc;
         fifo_data[wr_ptr] <= {asm_reg, imem_rdata};
      end
   end

endmodule

// File: tb/tb_ifetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_buffer
// Self-checking bench for ifetch_buffer with the default parameters
// (32-byte memory, 2-entry FIFO, reset PC 0). A behavioural byte memory
// answers imem_addr combinationally. Inputs change on the falling edge and
// outputs are compared on the following falling edge, one rising edge later.
// Memory image: bytes 0..7 = 20 04 00 05 8C 05 00 04, byte i (i>=8) = A0+i.
// ---------------------------------------------------------------------------
module tb_ifetch_buffer;

   logic        clk;
   logic        reset;
   logic [4:0]  imem_addr;
   logic [7:0]  imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [1:0]  fifo_count;

   logic [7:0]  imem [32];

   int checks;
   int errors;

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic [31:0] ep;
      logic [1:0]  ec;
      logic [4:0]  ea;
   } vec_t;

   vec_t vecs [9];

   ifetch_buffer #(
      .ADDR_W   (5),
      .DEPTH    (2),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .fifo_count     (fifo_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational byte-wide instruction memory.
   assign imem_rdata = imem[imem_addr];

   task automatic apply_stimulus(input logic rst, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
      reset          = rst;
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_field(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_output(input string tag, input logic ev,
                               input logic [31:0] ed, input logic [31:0] ep,
                               input logic [1:0] ec, input logic [4:0] ea);
      check_field({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, ev});
      check_field({tag, ".data"},  inst_data, ed);
      check_field({tag, ".pc"},    inst_pc, ep);
      check_field({tag, ".count"}, {30'h0, fifo_count}, {30'h0, ec});
      check_field({tag, ".addr"},  {27'h0, imem_addr}, {27'h0, ea});
   endtask

   task automatic do_reset();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;

      imem[0] = 8'h20; imem[1] = 8'h04; imem[2] = 8'h00; imem[3] = 8'h05;
      imem[4] = 8'h8C; imem[5] = 8'h05; imem[6] = 8'h00; imem[7] = 8'h04;
      for (int i = 8; i < 32; i++) begin
         imem[i] = 8'(8'hA0 + i);
      end

      // Streaming from reset with the consumer always ready.
      vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd0};
      vecs[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd1};
      vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd2};
      vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd3};
      vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20040005, 32'h0, 2'd1, 5'd4};
      vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd5};
      vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd6};
      vecs[7] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        32'h0, 2'd0, 5'd7};
      vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8C050004, 32'h4, 2'd1, 5'd8};

      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      for (int v = 0; v < 9; v++) begin
         apply_stimulus(vecs[v].rst, vecs[v].rv, vecs[v].rpc, vecs[v].rdy);
         tick();
         check_output($sformatf("stream%0d", v), vecs[v].ev, vecs[v].ed,
                      vecs[v].ep, vecs[v].ec, vecs[v].ea);
      end

      // Back-pressure: fill, stall, single pop, refill.
      do_reset();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (8) tick();
      check_output("full", 1'b1, 32'h20040005, 32'h0, 2'd2, 5'd8);
      repeat (2) tick();
      check_output("stall", 1'b1, 32'h20040005, 32'h0, 2'd2, 5'd8);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      check_output("pop_full", 1'b1, 32'h8C050004, 32'h4, 2'd1, 5'd9);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (3) tick();
      check_output("refill", 1'b1, 32'h8C050004, 32'h4, 2'd2, 5'd12);

      // Redirect mid-assembly to an unaligned PC.
      do_reset();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (2) tick();
      check_output("pre_redir", 1'b0, 32'h0, 32'h0, 2'd0, 5'd2);
      apply_stimulus(1'b0, 1'b1, 32'h0000000E, 1'b1);
      tick();
      check_output("redir", 1'b0, 32'h0, 32'h0, 2'd0, 5'd12);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) tick();
      check_output("redir_lat", 1'b0, 32'h0, 32'h0, 2'd0, 5'd15);
      tick();
      check_output("redir_word", 1'b1, 32'hACADAEAF, 32'hC, 2'd1, 5'd16);

      // Redirect near the top of memory: address wraps, PC keeps counting.
      do_reset();
      apply_stimulus(1'b0, 1'b1, 32'h1C, 1'b0);
      tick();
      check_output("wrap_redir", 1'b0, 32'h0, 32'h0, 2'd0, 5'd28);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (4) tick();
      check_output("wrap_word", 1'b1, 32'hBCBDBEBF, 32'h1C, 2'd1, 5'd0);
      repeat (4) tick();
      check_output("wrap_full", 1'b1, 32'hBCBDBEBF, 32'h1C, 2'd2, 5'd4);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      check_output("wrap_next", 1'b1, 32'h20040005, 32'h20, 2'd1, 5'd5);

      // Redirect with a simultaneous pop while full.
      do_reset();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (8) tick();
      check_output("rp_full", 1'b1, 32'h20040005, 32'h0, 2'd2, 5'd8);
      apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1);
      tick();
      check_output("rp_flush", 1'b0, 32'h0, 32'h0, 2'd0, 5'd16);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_output($sformatf("rp_empty%0d", k), 1'b0, 32'h0, 32'h0, 2'd0,
                      5'(16 + k));
      end
      tick();
      check_output("rp_word", 1'b1, 32'hB0B1B2B3, 32'h10, 2'd1, 5'd20);

      // Reset mid-assembly at the push byte, together with a redirect.
      do_reset();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (7) tick();
      check_output("pre_rst", 1'b1, 32'h20040005, 32'h0, 2'd1, 5'd7);
      apply_stimulus(1'b1, 1'b1, 32'h10, 1'b1);
      tick();
      check_output("rst_mid", 1'b0, 32'h0, 32'h0, 2'd0, 5'd0);
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      check_output("post_rst", 1'b0, 32'h0, 32'h0, 2'd0, 5'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
